// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode stage: opcodes, functs, ALU operation
// codes and the layout of the packed control word handed to execute.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_e;

    // Field order matches the id_ctrl bit layout, MSB first.
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        logic    branch;
        logic    bne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    localparam int CTRL_W          = 12;
    localparam int CTRL_REG_WRITE  = 11;
    localparam int CTRL_MEM_READ   = 10;
    localparam int CTRL_MEM_WRITE  = 9;
    localparam int CTRL_MEM_TO_REG = 8;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_REG_DST    = 6;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_BNE        = 4;
    localparam int CTRL_JUMP       = 3;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, r0 hardwired to zero, synchronous clear.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_regs [32];
    logic [4:0]  w_ra   [2];
    logic [31:0] w_rd   [2];

    assign w_ra[0] = i_ra1;
    assign w_ra[1] = i_ra2;
    assign o_rd1   = w_rd[0];
    assign o_rd2   = w_rd[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // The bypass lets a same-cycle write-back reach the operand latched into ID/EX.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                if (w_ra[gi] == 5'd0) begin
                    w_rd[gi] = '0;
                end else if (i_we && (i_wa == w_ra[gi])) begin
                    w_rd[gi] = i_wd;
                end else begin
                    w_rd[gi] = r_regs[w_ra[gi]];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, control and
// immediate decode, branch/jump targets, load-use stall, and the ID/EX register.
module mips_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_valid,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [11:0] id_ctrl,
    output logic [31:0] id_branch_target,
    output logic [31:0] id_jump_target,
    output logic        id_illegal
);

    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_inst;

    logic        r_idex_valid;
    logic [31:0] r_idex_pc;
    logic [31:0] r_idex_rs_data;
    logic [31:0] r_idex_rt_data;
    logic [31:0] r_idex_imm;
    logic [4:0]  r_idex_rs;
    logic [4:0]  r_idex_rt;
    logic [4:0]  r_idex_rd;
    ctrl_t       r_idex_ctrl;
    logic [31:0] r_idex_btgt;
    logic [31:0] r_idex_jtgt;
    logic        r_idex_illegal;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    logic [31:0] w_sext;
    logic [31:0] w_pc_plus4;
    ctrl_t       w_ctrl;
    logic        w_illegal;
    logic        w_uses_rt;
    logic [31:0] w_imm;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_stall;

    assign w_op       = r_ifid_inst[31:26];
    assign w_rs       = r_ifid_inst[25:21];
    assign w_rt       = r_ifid_inst[20:16];
    assign w_rd       = r_ifid_inst[15:11];
    assign w_funct    = r_ifid_inst[5:0];
    assign w_imm16    = r_ifid_inst[15:0];
    assign w_sext     = sext16(w_imm16);
    assign w_pc_plus4 = r_ifid_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= RESET_PC;
            r_ifid_inst  <= NOP_WORD;
        end else if (flush) begin
            r_ifid_valid <= 1'b0;
        end else if (!w_stall) begin
            r_ifid_valid <= if_valid;
            r_ifid_pc    <= if_pc;
            r_ifid_inst  <= if_inst;
        end
    end

    mips_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_data),
        .o_rd2 (w_rt_data),
        .i_we  (wb_we),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        w_uses_rt = 1'b0;
        w_imm     = w_sext;
        case (w_op)
            OP_RTYPE: begin
                w_uses_rt        = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                case (w_funct)
                    FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                    FN_AND:  w_ctrl.alu_op = ALU_AND;
                    FN_OR:   w_ctrl.alu_op = ALU_OR;
                    FN_SLT:  w_ctrl.alu_op = ALU_SLT;
                    default: begin
                        w_ctrl    = '0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                w_uses_rt        = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                w_uses_rt     = 1'b1;
                w_ctrl.branch = 1'b1;
                w_ctrl.bne    = (w_op == OP_BNE);
                w_ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI, OP_SLTI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = (w_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            OP_ANDI, OP_ORI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = (w_op == OP_ORI) ? ALU_OR : ALU_AND;
                w_imm            = {16'h0000, w_imm16};
            end
            OP_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_LUI;
                w_imm            = {w_imm16, 16'h0000};
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Load-use check looks only at pipeline state, so fetch never sees a loop through stall.
    always_comb begin
        w_stall = 1'b0;
        if (!flush && r_ifid_valid && r_idex_valid && r_idex_ctrl.mem_read
            && (r_idex_rt != 5'd0)) begin
            w_stall = (r_idex_rt == w_rs) || (w_uses_rt && (r_idex_rt == w_rt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex_valid   <= 1'b0;
            r_idex_pc      <= RESET_PC;
            r_idex_rs_data <= '0;
            r_idex_rt_data <= '0;
            r_idex_imm     <= '0;
            r_idex_rs      <= '0;
            r_idex_rt      <= '0;
            r_idex_rd      <= '0;
            r_idex_ctrl    <= '0;
            r_idex_btgt    <= '0;
            r_idex_jtgt    <= '0;
            r_idex_illegal <= 1'b0;
        end else if (flush || w_stall) begin
            r_idex_valid   <= 1'b0;
            r_idex_ctrl    <= '0;
            r_idex_illegal <= 1'b0;
        end else begin
            r_idex_valid   <= r_ifid_valid;
            r_idex_pc      <= r_ifid_pc;
            r_idex_rs_data <= w_rs_data;
            r_idex_rt_data <= w_rt_data;
            r_idex_imm     <= w_imm;
            r_idex_rs      <= w_rs;
            r_idex_rt      <= w_rt;
            r_idex_rd      <= w_rd;
            r_idex_ctrl    <= r_ifid_valid ? w_ctrl : '0;
            r_idex_btgt    <= w_pc_plus4 + {w_sext[29:0], 2'b00};
            r_idex_jtgt    <= {w_pc_plus4[31:28], r_ifid_inst[25:0], 2'b00};
            r_idex_illegal <= r_ifid_valid & w_illegal;
        end
    end

    assign stall            = w_stall;
    assign id_valid         = r_idex_valid;
    assign id_pc            = r_idex_pc;
    assign id_rs_data       = r_idex_rs_data;
    assign id_rt_data       = r_idex_rt_data;
    assign id_imm           = r_idex_imm;
    assign id_rs            = r_idex_rs;
    assign id_rt            = r_idex_rt;
    assign id_rd            = r_idex_rd;
    assign id_ctrl          = r_idex_ctrl;
    assign id_branch_target = r_idex_btgt;
    assign id_jump_target   = r_idex_jtgt;
    assign id_illegal       = r_idex_illegal;

endmodule

// File: tb/tb_mips_id_stage.sv
// Directed bench for mips_id_stage: a decode vector table plus hand-written
// sequences for bypass, load-use stall, flush-during-stall and reset-mid-stall.
module tb_mips_id_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [11:0] id_ctrl;
    logic [31:0] id_branch_target;
    logic [31:0] id_jump_target;
    logic        id_illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mips_id_stage #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_inst          (if_inst),
        .if_valid         (if_valid),
        .flush            (flush),
        .wb_we            (wb_we),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .id_imm           (id_imm),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_ctrl          (id_ctrl),
        .id_branch_target (id_branch_target),
        .id_jump_target   (id_jump_target),
        .id_illegal       (id_illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic        ill;
        logic        chk_b;
        logic [31:0] btgt;
        logic        chk_j;
        logic [31:0] jtgt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        if_pc    = pc;
        if_inst  = inst;
        if_valid = 1'b1;
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] pc, input logic [31:0] inst,
                                input logic [11:0] ctrl, input logic [31:0] imm, input logic ill,
                                input logic cb, input logic [31:0] bt,
                                input logic cj, input logic [31:0] jt);
        vec_t v;
        v.name = n; v.pc = pc; v.inst = inst; v.ctrl = ctrl; v.imm = imm; v.ill = ill;
        v.chk_b = cb; v.btgt = bt; v.chk_j = cj; v.jtgt = jt;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk("addi",   32'h0000_0010, 32'h2001_0005, 12'h880, 32'h0000_0005, 0, 0, 0, 0, 0);
        vecs[1]  = mk("add",    32'h0000_0014, 32'h0060_2020, 12'h840, 32'h0000_2020, 0, 0, 0, 0, 0);
        vecs[2]  = mk("sub",    32'h0000_0018, 32'h0022_2822, 12'h841, 32'h0000_2822, 0, 0, 0, 0, 0);
        vecs[3]  = mk("and",    32'h0000_001C, 32'h0022_3024, 12'h842, 32'h0000_3024, 0, 0, 0, 0, 0);
        vecs[4]  = mk("or",     32'h0000_0020, 32'h0022_3825, 12'h843, 32'h0000_3825, 0, 0, 0, 0, 0);
        vecs[5]  = mk("slt",    32'h0000_0024, 32'h0022_402A, 12'h844, 32'h0000_402A, 0, 0, 0, 0, 0);
        vecs[6]  = mk("lw",     32'h0000_0028, 32'h8C22_0000, 12'hD80, 32'h0000_0000, 0, 0, 0, 0, 0);
        vecs[7]  = mk("sw",     32'h0000_002C, 32'hAC22_FFFC, 12'h280, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        vecs[8]  = mk("beq",    32'h0000_0100, 32'h1022_FFFF, 12'h021, 32'hFFFF_FFFF, 0, 1, 32'h0000_0100, 0, 0);
        vecs[9]  = mk("bne",    32'h0000_0200, 32'h1422_0003, 12'h031, 32'h0000_0003, 0, 1, 32'h0000_0210, 0, 0);
        vecs[10] = mk("andi",   32'h0000_0030, 32'h3023_8000, 12'h882, 32'h0000_8000, 0, 0, 0, 0, 0);
        vecs[11] = mk("ori",    32'h0000_0034, 32'h3423_8000, 12'h883, 32'h0000_8000, 0, 0, 0, 0, 0);
        vecs[12] = mk("slti",   32'h0000_0038, 32'h2823_FFFE, 12'h884, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        vecs[13] = mk("lui",    32'h0000_003C, 32'h3C03_1234, 12'h885, 32'h1234_0000, 0, 0, 0, 0, 0);
        vecs[14] = mk("j",      32'h0000_0000, 32'h0800_0040, 12'h008, 32'h0000_0040, 0, 0, 0, 1, 32'h0000_0100);
        vecs[15] = mk("j_hi",   32'hEFFF_FFFC, 32'h0800_0001, 12'h008, 32'h0000_0001, 0, 0, 0, 1, 32'hF000_0004);
        vecs[16] = mk("op3f",   32'h0000_0040, 32'hFC00_0000, 12'h000, 32'h0000_0000, 1, 0, 0, 0, 0);
        vecs[17] = mk("fn21",   32'h0000_0044, 32'h0022_1821, 12'h000, 32'h0000_1821, 1, 0, 0, 0, 0);

        rst = 1'b1; if_pc = '0; if_inst = '0; if_valid = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset valid",   {31'b0, id_valid}, 32'd0);
        chk("reset pc",      id_pc, RST_PC);
        chk("reset ctrl",    {20'b0, id_ctrl}, 32'd0);
        chk("reset imm",     id_imm, 32'd0);
        chk("reset illegal", {31'b0, id_illegal}, 32'd0);
        chk("reset stall",   {31'b0, stall}, 32'd0);
        $display("reset: valid=%0b pc=0x%08h stall=%0b", id_valid, id_pc, stall);

        for (int i = 0; i < 18; i++) begin
            present(vecs[i].pc, vecs[i].inst);
            tick();
            if_valid = 1'b0;
            tick();
            chk({vecs[i].name, " valid"}, {31'b0, id_valid}, 32'd1);
            chk({vecs[i].name, " pc"},    id_pc, vecs[i].pc);
            chk({vecs[i].name, " ctrl"},  {20'b0, id_ctrl}, {20'b0, vecs[i].ctrl});
            chk({vecs[i].name, " imm"},   id_imm, vecs[i].imm);
            chk({vecs[i].name, " ill"},   {31'b0, id_illegal}, {31'b0, vecs[i].ill});
            chk({vecs[i].name, " rs"},    {27'b0, id_rs}, {27'b0, vecs[i].inst[25:21]});
            chk({vecs[i].name, " rt"},    {27'b0, id_rt}, {27'b0, vecs[i].inst[20:16]});
            chk({vecs[i].name, " rd"},    {27'b0, id_rd}, {27'b0, vecs[i].inst[15:11]});
            if (vecs[i].chk_b) chk({vecs[i].name, " btgt"}, id_branch_target, vecs[i].btgt);
            if (vecs[i].chk_j) chk({vecs[i].name, " jtgt"}, id_jump_target, vecs[i].jtgt);
            $display("vec %0d %s: inst=0x%08h ctrl=0x%03h imm=0x%08h ill=%0b",
                     i, vecs[i].name, vecs[i].inst, id_ctrl, id_imm, id_illegal);
        end

        // Write-through bypass into add $4,$3,$0, then an r0 write that must stay invisible.
        present(32'h0000_0300, 32'h0060_2020);
        tick();
        if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_we = 1'b0;
        chk("bypass rs_data", id_rs_data, 32'hDEAD_BEEF);
        $display("bypass: rs_data=0x%08h", id_rs_data);
        present(32'h0000_0304, 32'h0003_2020);
        tick();
        if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        tick();
        wb_we = 1'b0;
        chk("r0 rs_data",     id_rs_data, 32'd0);
        chk("stored rt_data", id_rt_data, 32'hDEAD_BEEF);
        $display("r0 write: rs_data=0x%08h rt_data=0x%08h", id_rs_data, id_rt_data);

        // lw $2,0($1) then add $5,$2,$2: one stall cycle, one bubble, then the add.
        present(32'h0000_0400, 32'h8C22_0000);
        tick();
        present(32'h0000_0404, 32'h0042_2820);
        tick();
        chk("lu stall",      {31'b0, stall}, 32'd1);
        chk("lu lw ctrl",    {20'b0, id_ctrl}, 32'h0000_0D80);
        tick();
        chk("lu bubble val", {31'b0, id_valid}, 32'd0);
        chk("lu bubble ctl", {20'b0, id_ctrl}, 32'd0);
        chk("lu stall off",  {31'b0, stall}, 32'd0);
        if_valid = 1'b0;
        tick();
        chk("lu add valid",  {31'b0, id_valid}, 32'd1);
        chk("lu add pc",     id_pc, 32'h0000_0404);
        chk("lu add ctrl",   {20'b0, id_ctrl}, 32'h0000_0840);
        $display("load-use: add issued pc=0x%08h ctrl=0x%03h", id_pc, id_ctrl);

        // lw $2 then add $5,$3,$3 and ori $2,$3,1: neither depends on $2 as a source.
        present(32'h0000_0500, 32'h8C22_0000);
        tick();
        present(32'h0000_0504, 32'h0063_2820);
        tick();
        chk("nodep add stall", {31'b0, stall}, 32'd0);
        present(32'h0000_0508, 32'h8C22_0000);
        tick();
        chk("nodep add pc",    id_pc, 32'h0000_0504);
        present(32'h0000_050C, 32'h3462_0001);
        tick();
        chk("nodep ori stall", {31'b0, stall}, 32'd0);
        if_valid = 1'b0;
        tick();
        chk("nodep ori ctrl",  {20'b0, id_ctrl}, 32'h0000_0883);
        $display("no-dependency: stall=%0b ctrl=0x%03h", stall, id_ctrl);

        // Flush while stalled discards the held add.
        present(32'h0000_0600, 32'h8C22_0000);
        tick();
        present(32'h0000_0604, 32'h0042_2820);
        tick();
        chk("fl pre stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl stall off", {31'b0, stall}, 32'd0);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        #1;
        chk("fl valid",     {31'b0, id_valid}, 32'd0);
        chk("fl stall",     {31'b0, stall}, 32'd0);
        tick();
        chk("fl discard",   {31'b0, id_valid}, 32'd0);
        $display("flush-in-stall: id_valid=%0b stall=%0b", id_valid, stall);

        // Reset while stalled empties the pipeline.
        present(32'h0000_0700, 32'h8C22_0000);
        tick();
        present(32'h0000_0704, 32'h0042_2820);
        tick();
        chk("rs pre stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; if_valid = 1'b0;
        #1;
        chk("rs valid",     {31'b0, id_valid}, 32'd0);
        chk("rs stall",     {31'b0, stall}, 32'd0);
        chk("rs pc",        id_pc, RST_PC);
        tick();
        chk("rs empty",     {31'b0, id_valid}, 32'd0);
        $display("reset-in-stall: id_valid=%0b pc=0x%08h", id_valid, id_pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
